riscv_mem_arbiter: RTL



---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/riscv_mem_arb_pick.sv | 14 +
 rtl/riscv_mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and default parameters for the unified-memory arbiter.
// The state and owner encodings are common to the top level and the testbench.
package riscv_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_TIMEOUT         = 16;

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Combinational request picker: data has priority until its consecutive-grant
// streak saturates while fetch waits, then fetch wins once.
module riscv_mem_arb_pick (
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic streak_sat_i,
    output logic grant_if_o,
    output logic grant_dm_o
);

    assign grant_dm_o = dm_req_i && !(if_req_i && streak_sat_i);
    assign grant_if_o = if_req_i && !grant_dm_o;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one single-port memory between the
// instruction-fetch and data ports, with starvation limit and access watchdog.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int TIMEOUT         = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    output logic              err_o
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              grant_if, grant_dm;
    logic              idle, busy;
    logic              accept;
    logic              tmo_hit;
    logic              complete;
    logic [DATA_W-1:0] resp_data;

    // Byte-offset bits are intentionally dropped; there is no misalignment handling.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

    riscv_mem_arb_pick u_pick (
        .if_req_i     (if_req_i),
        .dm_req_i     (dm_req_i),
        .streak_sat_i (streak_q == STREAK_MAX),
        .grant_if_o   (grant_if),
        .grant_dm_o   (grant_dm)
    );

    assign idle      = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign accept    = idle && (grant_if || grant_dm);
    // An ack on the terminal count wins over the abort.
    assign tmo_hit   = busy && !mem_ack_i && (tmo_q == TMO_LAST);
    assign complete  = busy && (mem_ack_i || tmo_hit);
    assign resp_data = (mem_ack_i && !we_q) ? mem_rdata_i : '0;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = BUSY;
            BUSY:    if (complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        if_ready_o = 1'b0;
        dm_ready_o = 1'b0;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if_ready_o = grant_if;
                dm_ready_o = grant_dm;
            end
            BUSY: begin
                mem_en_o = 1'b1;
                mem_we_o = we_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        streak_d    = streak_q;
        tmo_d       = '0;
        err_d       = err_q | tmo_hit;
        if_rvalid_d = complete && (owner_q == OWN_IF);
        dm_rvalid_d = complete && (owner_q == OWN_DM);
        if_rdata_d  = if_rvalid_d ? resp_data : if_rdata_q;
        dm_rdata_d  = dm_rvalid_d ? resp_data : dm_rdata_q;

        if (accept) begin
            if (grant_dm) begin
                owner_d = OWN_DM;
                addr_d  = dm_addr_i[ADDR_W-1:2];
                we_d    = dm_we_i;
                wdata_d = dm_wdata_i;
                if (!if_req_i)
                    streak_d = '0;
                else if (streak_q != STREAK_MAX)
                    streak_d = streak_q + 1'b1;
            end else begin
                owner_d  = OWN_IF;
                addr_d   = if_addr_i[ADDR_W-1:2];
                we_d     = 1'b0;
                wdata_d  = '0;
                streak_d = '0;
            end
        end

        if (busy && !complete)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            streak_q    <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign err_o       = err_q;

endmodule
